// File: rtl/riscv_pkg.sv
// Shared load-unit definitions: funct3 load encodings, the load FSM state type
// and small decode helpers used by both the FSM and the alignment datapath.
package riscv_pkg;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD0,
        ST_CAP0,
        ST_RD1,
        ST_CAP1,
        ST_RESP
    } load_state_t;

    function automatic logic f3_legal(input logic [2:0] funct3);
        return (funct3 == F3_LB)  || (funct3 == F3_LH) || (funct3 == F3_LW) ||
               (funct3 == F3_LBU) || (funct3 == F3_LHU);
    endfunction

    // True when the access crosses into the next word.
    function automatic logic f3_spans(input logic [2:0] funct3, input logic [1:0] offset);
        logic result;
        result = 1'b0;
        if ((funct3 == F3_LH) || (funct3 == F3_LHU)) begin
            result = (offset == 2'd3);
        end else if (funct3 == F3_LW) begin
            result = (offset != 2'd0);
        end
        return result;
    endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load alignment: little-endian byte/halfword/word extraction
// from a two-word window followed by sign or zero extension.
module load_align
    import riscv_pkg::*;
(
    input  logic [63:0] data,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [63:0] shifted;

    assign shifted = data >> {offset, 3'b000};

    always_comb begin
        result = 32'd0;
        case (funct3)
            F3_LB:   result = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   result = {{16{shifted[15]}}, shifted[15:0]};
            F3_LW:   result = shifted[31:0];
            F3_LBU:  result = {24'd0, shifted[7:0]};
            F3_LHU:  result = {16'd0, shifted[15:0]};
            default: result = 32'd0;
        endcase
    end

endmodule

// File: rtl/mem_load_unit.sv
// Multi-cycle load engine issuing word-aligned RAM reads and returning the
// extended result. Macro MEM_LOAD_MISALIGNED_EN enables two-word spanning loads.
module mem_load_unit
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_err,
    output logic        mem_rd_en,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata
);

    load_state_t state_reg;
    load_state_t state_next;

    logic [31:0] addr_reg;
    logic [2:0]  funct3_reg;
    logic        err_reg;
    logic [31:0] lo_reg;
    logic [31:0] word_base;
    logic [63:0] align_data;
    logic [31:0] align_result;
    logic        accept;
    logic        accept_err;

    assign word_base = {addr_reg[31:2], 2'b00};
    assign accept    = (state_reg == ST_IDLE) && req_valid;

`ifdef MEM_LOAD_MISALIGNED_EN
    logic [31:0] hi_reg;
    assign accept_err = !f3_legal(req_funct3);
    assign align_data = {hi_reg, lo_reg};
`else
    assign accept_err = !f3_legal(req_funct3) || f3_spans(req_funct3, req_addr[1:0]);
    assign align_data = {32'd0, lo_reg};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        req_ready  = 1'b0;
        mem_rd_en  = 1'b0;
        mem_addr   = 32'd0;
        resp_valid = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = accept_err ? ST_RESP : ST_RD0;
                end
            end
            ST_RD0: begin
                mem_rd_en  = 1'b1;
                mem_addr   = word_base;
                state_next = ST_CAP0;
            end
            ST_CAP0: begin
`ifdef MEM_LOAD_MISALIGNED_EN
                state_next = f3_spans(funct3_reg, addr_reg[1:0]) ? ST_RD1 : ST_RESP;
`else
                state_next = ST_RESP;
`endif
            end
`ifdef MEM_LOAD_MISALIGNED_EN
            ST_RD1: begin
                mem_rd_en  = 1'b1;
                mem_addr   = word_base + 32'd4;
                state_next = ST_CAP1;
            end
            ST_CAP1: begin
                state_next = ST_RESP;
            end
`endif
            ST_RESP: begin
                resp_valid = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_reg   <= 32'd0;
            funct3_reg <= 3'd0;
            err_reg    <= 1'b0;
            lo_reg     <= 32'd0;
        end else begin
            if (accept) begin
                addr_reg   <= req_addr;
                funct3_reg <= req_funct3;
                err_reg    <= accept_err;
            end
            if (state_reg == ST_CAP0) begin
                lo_reg <= mem_rdata;
            end
        end
    end

`ifdef MEM_LOAD_MISALIGNED_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_reg <= 32'd0;
        end else if (state_reg == ST_CAP1) begin
            hi_reg <= mem_rdata;
        end
    end
`endif

    load_align u_align (
        .data   (align_data),
        .offset (addr_reg[1:0]),
        .funct3 (funct3_reg),
        .result (align_result)
    );

    // Outputs are forced to zero outside RESP so they sit at reset values when idle.
    assign resp_data = (state_reg == ST_RESP && !err_reg) ? align_result : 32'd0;
    assign resp_err  = (state_reg == ST_RESP) && err_reg;

endmodule

// File: tb/tb_mem_load_unit.sv
// Scoreboard bench for mem_load_unit: directed loads push expected responses and
// RAM reads into queues; a monitor pops and compares as the DUT presents them.
module tb_mem_load_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = 32'd0;
    logic [2:0]  req_funct3 = 3'd0;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_err;
    logic        mem_rd_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata = 32'd0;

    mem_load_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_funct3 (req_funct3),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
        int          acc;
        string       name;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] rd_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] ram_word(input logic [31:0] a);
        logic [31:0] w;
        case (a)
            32'h0000_0000: w = 32'h1234_5678;
            32'h0000_0004: w = 32'h9ABC_DEF0;
            default:       w = a ^ 32'hA5A5_A5A5;
        endcase
        return w;
    endfunction

    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= ram_word(mem_addr);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (resp_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: got data 0x%08h err %0b expected no response",
                             resp_data, resp_err);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check({e.name, "_data"}, resp_data, e.data);
                    check({e.name, "_err"}, {31'd0, resp_err}, {31'd0, e.err});
                    check({e.name, "_latency"}, cyc - e.acc + 1, e.lat);
                    check({e.name, "_ready_in_resp"}, {31'd0, req_ready}, 32'd0);
                    $display("resp %s data=0x%08h err=%0b cycle=%0d", e.name, resp_data,
                             resp_err, cyc - e.acc + 1);
                end
            end
            if (mem_rd_en) begin
                if (rd_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_read: got mem_addr 0x%08h expected no read", mem_addr);
                end else begin
                    check("mem_addr", mem_addr, rd_q.pop_front());
                end
            end
        end
    end

    // Present a request (valid stays high afterwards) and queue its expectations.
    task automatic issue(input string name, input logic [31:0] a, input logic [2:0] f,
                         input logic [31:0] d, input logic e, input int lat,
                         input int nrd, input logic [31:0] ra1);
        int guard;
        exp_t x;
        @(negedge clk);
        req_valid  = 1'b1;
        req_addr   = a;
        req_funct3 = f;
        guard = 0;
        while (!req_ready && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL %s_accept_timeout: req_ready stayed 0, expected 1", name);
            req_valid = 1'b0;
            return;
        end
        if (nrd >= 1) rd_q.push_back({a[31:2], 2'b00});
        if (nrd >= 2) rd_q.push_back(ra1);
        @(posedge clk);
        #1;
        x.data = d;
        x.err  = e;
        x.lat  = lat;
        x.acc  = cyc;
        x.name = name;
        exp_q.push_back(x);
    endtask

    task automatic drop_valid();
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"},  {31'd0, req_ready},  32'd1);
        check({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
        check({tag, "_resp_data"},  resp_data,           32'd0);
        check({tag, "_resp_err"},   {31'd0, resp_err},   32'd0);
        check({tag, "_mem_rd_en"},  {31'd0, mem_rd_en},  32'd0);
        check({tag, "_mem_addr"},   mem_addr,            32'd0);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d responses outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #3;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        issue("lw_0x0", 32'h0, 3'd2, 32'h1234_5678, 1'b0, 3, 1, 32'h0);
        drop_valid();
        drain();
        issue("lb_0x7", 32'h7, 3'd0, 32'hFFFF_FF9A, 1'b0, 3, 1, 32'h0);
        issue("lbu_0x7", 32'h7, 3'd4, 32'h0000_009A, 1'b0, 3, 1, 32'h0);
        issue("lh_0x4", 32'h4, 3'd1, 32'hFFFF_DEF0, 1'b0, 3, 1, 32'h0);
        issue("lhu_0x6", 32'h6, 3'd5, 32'h0000_9ABC, 1'b0, 3, 1, 32'h0);
        drop_valid();
        drain();

`ifdef MEM_LOAD_MISALIGNED_EN
        issue("lw_0x2", 32'h2, 3'd2, 32'hDEF0_1234, 1'b0, 5, 2, 32'h4);
        issue("lhu_0x3", 32'h3, 3'd5, 32'h0000_F012, 1'b0, 5, 2, 32'h4);
        issue("lw_wrap", 32'hFFFF_FFFE, 3'd2, 32'h5678_5A5A, 1'b0, 5, 2, 32'h0);
`else
        issue("lw_0x2", 32'h2, 3'd2, 32'h0, 1'b1, 1, 0, 32'h0);
        issue("lhu_0x3", 32'h3, 3'd5, 32'h0, 1'b1, 1, 0, 32'h0);
        issue("lw_wrap", 32'hFFFF_FFFE, 3'd2, 32'h0, 1'b1, 1, 0, 32'h0);
`endif
        issue("f3_3", 32'h0, 3'd3, 32'h0, 1'b1, 1, 0, 32'h0);
        issue("f3_7", 32'h4, 3'd7, 32'h0, 1'b1, 1, 0, 32'h0);
        drop_valid();
        drain();

        issue("b2b_lb_0x1", 32'h1, 3'd0, 32'h0000_0056, 1'b0, 3, 1, 32'h0);
        issue("b2b_lb_0x2", 32'h2, 3'd0, 32'h0000_0034, 1'b0, 3, 1, 32'h0);
        drop_valid();
        drain();

`ifdef MEM_LOAD_MISALIGNED_EN
        issue("rst_lw", 32'h2, 3'd2, 32'h0, 1'b0, 5, 2, 32'h4);
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
`else
        issue("rst_lw", 32'h0, 3'd2, 32'h0, 1'b0, 3, 1, 32'h0);
        req_valid = 1'b0;
        repeat (1) @(posedge clk);
`endif
        #2;
        rst_n = 1'b0;
        void'(exp_q.pop_back());
        #1;
        check_reset_outputs("midop_reset");
        @(negedge clk);
        rst_n = 1'b1;
        check("midop_reads_left", rd_q.size(), 32'd0);
        rd_q.delete();
        repeat (6) @(negedge clk);

        issue("lw_after_rst", 32'h0, 3'd2, 32'h1234_5678, 1'b0, 3, 1, 32'h0);
        drop_valid();
        drain();
        repeat (4) @(negedge clk);
        check("final_reads_left", rd_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
